// File: rtl/sc_dmem_mmio.sv
// Data memory with memory-mapped I/O: RAM below addr[7], output/input ports and change status above.
// Optional input change detection with IRQ is built when SC_DMEM_CHANGE_DETECT_EN is defined.
module sc_dmem_mmio #(
    parameter int DEPTH_LOG2 = 5,
    parameter int NUM_OUT    = 4,
    parameter int NUM_IN     = 3
) (
    input  logic                    clock_i,
    input  logic                    reset_i,
    input  logic [31:0]             addr_i,
    input  logic [31:0]             datain_i,
    input  logic                    we_i,
    input  logic [3:0]              be_i,
    input  logic                    re_i,
    output logic [31:0]             dataout_o,
    output logic                    rvalid_o,
    input  logic [32*NUM_IN-1:0]    in_port_i,
    output logic [32*NUM_OUT-1:0]   out_port_o,
    output logic                    irq_o
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;

    logic [DEPTH_LOG2-1:0] ram_idx;
    logic [4:0]            io_idx;
    logic                  is_io;
    logic                  ram_we;
    logic                  io_we;
    logic                  unused_addr;

    assign ram_idx     = addr_i[DEPTH_LOG2+1:2];
    assign io_idx      = addr_i[6:2];
    assign is_io       = addr_i[7];
    assign ram_we      = we_i & ~reset_i & ~is_io;
    assign io_we       = we_i & ~reset_i & is_io;
    assign unused_addr = ^{addr_i[31:8], addr_i[1:0]};

    function automatic logic [31:0] lane_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  lanes);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) begin
            r[8*i +: 8] = lanes[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
        end
        return r;
    endfunction

    // RAM has no reset; reads see pre-write content because of the registered read path
    logic [31:0] mem_q [DEPTH];

    always_ff @(posedge clock_i) begin
        if (ram_we) begin
            mem_q[ram_idx] <= lane_merge(mem_q[ram_idx], datain_i, be_i);
        end
    end

    logic [31:0] sync1_q [NUM_IN];
    logic [31:0] sync2_q [NUM_IN];

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            for (int k = 0; k < NUM_IN; k++) begin
                sync1_q[k] <= '0;
                sync2_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_IN; k++) begin
                sync1_q[k] <= in_port_i[32*k +: 32];
                sync2_q[k] <= sync1_q[k];
            end
        end
    end

    logic [31:0] out_q [NUM_OUT];

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            for (int j = 0; j < NUM_OUT; j++) begin
                out_q[j] <= '0;
            end
        end else if (io_we) begin
            for (int j = 0; j < NUM_OUT; j++) begin
                if (io_idx == 5'(j)) begin
                    out_q[j] <= lane_merge(out_q[j], datain_i, be_i);
                end
            end
        end
    end

    logic [NUM_IN-1:0] status_q;
    logic              irq_q;

`ifdef SC_DMEM_CHANGE_DETECT_EN
    logic [31:0]       prev_q [NUM_IN];
    logic [NUM_IN-1:0] chg;
    logic [NUM_IN-1:0] clr;
    logic [NUM_IN-1:0] status_d;

    // A new change event takes priority over a write-one-to-clear in the same cycle
    always_comb begin
        chg = '0;
        clr = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            chg[k] = (sync2_q[k] != prev_q[k]);
            clr[k] = io_we && (io_idx == 5'(NUM_IN)) && be_i[k/8] && datain_i[k];
        end
        status_d = (status_q & ~clr) | chg;
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            for (int k = 0; k < NUM_IN; k++) begin
                prev_q[k] <= '0;
            end
            status_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            for (int k = 0; k < NUM_IN; k++) begin
                prev_q[k] <= sync2_q[k];
            end
            status_q <= status_d;
            irq_q    <= |status_q;
        end
    end
`else
    assign status_q = '0;
    assign irq_q    = 1'b0;
`endif

    logic [31:0] rd_io;

    always_comb begin
        rd_io = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (io_idx == 5'(k)) begin
                rd_io = sync2_q[k];
            end
        end
        if (io_idx == 5'(NUM_IN)) begin
            rd_io = 32'(status_q);
        end
        for (int j = 0; j < NUM_OUT; j++) begin
            if (io_idx == 5'(16 + j)) begin
                rd_io = out_q[j];
            end
        end
    end

    logic [31:0] dataout_q;
    logic        rvalid_q;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            dataout_q <= '0;
            rvalid_q  <= 1'b0;
        end else begin
            rvalid_q <= re_i;
            if (re_i) begin
                dataout_q <= is_io ? rd_io : mem_q[ram_idx];
            end
        end
    end

    assign dataout_o = dataout_q;
    assign rvalid_o  = rvalid_q;
    assign irq_o     = irq_q;

    for (genvar g = 0; g < NUM_OUT; g++) begin : g_out
        assign out_port_o[32*g +: 32] = out_q[g];
    end

endmodule
